// File: rtl/alu_operand_stage.sv
// ============================================================================
// Module   : alu_operand_stage
// Brief    : RV32I ID/EX operand register with MEM/WB forwarding, shifter
//            control decode, valid/ready handoff, flush and stall counter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_operand_stage (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        id_valid,
  output logic        id_ready,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_rs1_data,
  input  logic [31:0] id_rs2_data,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic [4:0]  id_rd_addr,
  input  logic [3:0]  id_alu_op,
  input  logic        id_use_imm,
  input  logic        id_flush,
  input  logic        mem_fwd_en,
  input  logic [4:0]  mem_fwd_rd,
  input  logic [31:0] mem_fwd_data,
  input  logic        wb_fwd_en,
  input  logic [4:0]  wb_fwd_rd,
  input  logic [31:0] wb_fwd_data,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [31:0] ex_op_a,
  output logic [31:0] ex_op_b,
  output logic [4:0]  ex_shamt,
  output logic        ex_shift_sel,
  output logic        ex_shift_arith,
  output logic [3:0]  ex_alu_op,
  output logic [4:0]  ex_rd_addr,
  output logic [31:0] ex_pc,
  output logic [15:0] ex_stall_cnt
);

  localparam logic [3:0]  C_OP_SRL   = 4'd6;
  localparam logic [3:0]  C_OP_SRA   = 4'd7;
  localparam logic [3:0]  C_OP_MAX   = 4'd9;
  localparam logic [15:0] C_CNT_MAX  = 16'hFFFF;

  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        w_capture;
  logic        w_drain;
  logic        w_hold;
  logic [31:0] w_fwd_rs1;
  logic [31:0] w_fwd_rs2;
  logic [3:0]  w_op_norm;

  logic [31:0] r_op_a;
  logic [31:0] r_op_b;
  logic [3:0]  r_alu_op;
  logic        r_shift_sel;
  logic        r_shift_arith;
  logic [4:0]  r_rd_addr;
  logic [31:0] r_pc;
  logic [4:0]  r_rs1_addr;
  logic [4:0]  r_rs2_addr;
  logic        r_use_imm;
  logic [15:0] r_stall_cnt;

  // MEM beats WB; x0 never takes a forwarded value, so the fallback is kept.
  function automatic logic [31:0] fwd_pick(
    input logic [4:0]  idx,
    input logic [31:0] fallback,
    input logic        m_en,
    input logic [4:0]  m_rd,
    input logic [31:0] m_data,
    input logic        w_en,
    input logic [4:0]  w_rd,
    input logic [31:0] w_data
  );
    logic [31:0] res;
    res = fallback;
    if (idx != 5'd0 && m_en && m_rd == idx)      res = m_data;
    else if (idx != 5'd0 && w_en && w_rd == idx) res = w_data;
    return res;
  endfunction

  assign ex_valid  = (r_state == S_FULL);
  assign id_ready  = !ex_valid || ex_ready;
  assign w_capture = id_valid && id_ready && !id_flush;
  assign w_drain   = ex_valid && ex_ready;
  assign w_hold    = ex_valid && !ex_ready && !id_flush;

  assign w_fwd_rs1 = fwd_pick(id_rs1_addr, id_rs1_data, mem_fwd_en, mem_fwd_rd,
                              mem_fwd_data, wb_fwd_en, wb_fwd_rd, wb_fwd_data);
  assign w_fwd_rs2 = fwd_pick(id_rs2_addr, id_rs2_data, mem_fwd_en, mem_fwd_rd,
                              mem_fwd_data, wb_fwd_en, wb_fwd_rd, wb_fwd_data);
  assign w_op_norm = (id_alu_op > C_OP_MAX) ? 4'd0 : id_alu_op;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_EMPTY;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (id_flush)       w_state_nxt = S_EMPTY;
    else if (w_capture) w_state_nxt = S_FULL;
    else if (w_drain)   w_state_nxt = S_EMPTY;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_op_a        <= 32'd0;
      r_op_b        <= 32'd0;
      r_alu_op      <= 4'd0;
      r_shift_sel   <= 1'b0;
      r_shift_arith <= 1'b0;
      r_rd_addr     <= 5'd0;
      r_pc          <= 32'd0;
      r_rs1_addr    <= 5'd0;
      r_rs2_addr    <= 5'd0;
      r_use_imm     <= 1'b0;
    end else if (w_capture) begin
      r_op_a        <= w_fwd_rs1;
      r_op_b        <= id_use_imm ? id_imm : w_fwd_rs2;
      r_alu_op      <= w_op_norm;
      r_shift_sel   <= (w_op_norm == C_OP_SRL) || (w_op_norm == C_OP_SRA);
      r_shift_arith <= (w_op_norm == C_OP_SRA);
      r_rd_addr     <= id_rd_addr;
      r_pc          <= id_pc;
      r_rs1_addr    <= id_rs1_addr;
      r_rs2_addr    <= id_rs2_addr;
      r_use_imm     <= id_use_imm;
    end else if (w_hold) begin
      // Late producers update the parked operands; immediates are left alone.
      r_op_a <= fwd_pick(r_rs1_addr, r_op_a, mem_fwd_en, mem_fwd_rd,
                         mem_fwd_data, wb_fwd_en, wb_fwd_rd, wb_fwd_data);
      if (!r_use_imm) begin
        r_op_b <= fwd_pick(r_rs2_addr, r_op_b, mem_fwd_en, mem_fwd_rd,
                           mem_fwd_data, wb_fwd_en, wb_fwd_rd, wb_fwd_data);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                                 r_stall_cnt <= 16'd0;
    else if (w_hold && r_stall_cnt != C_CNT_MAX)  r_stall_cnt <= r_stall_cnt + 16'd1;
  end

  assign ex_op_a        = r_op_a;
  assign ex_op_b        = r_op_b;
  assign ex_shamt       = r_op_b[4:0];
  assign ex_shift_sel   = r_shift_sel;
  assign ex_shift_arith = r_shift_arith;
  assign ex_alu_op      = r_alu_op;
  assign ex_rd_addr     = r_rd_addr;
  assign ex_pc          = r_pc;
  assign ex_stall_cnt   = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
// ============================================================================
// Module   : tb_alu_operand_stage
// Brief    : Directed and random checks of alu_operand_stage against a model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_operand_stage;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        id_valid, id_ready;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic [3:0]  id_alu_op;
  logic        id_use_imm, id_flush;
  logic        mem_fwd_en, wb_fwd_en;
  logic [4:0]  mem_fwd_rd, wb_fwd_rd;
  logic [31:0] mem_fwd_data, wb_fwd_data;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_op_a, ex_op_b, ex_pc;
  logic [4:0]  ex_shamt, ex_rd_addr;
  logic        ex_shift_sel, ex_shift_arith;
  logic [3:0]  ex_alu_op;
  logic [15:0] ex_stall_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Reference slot contents
  bit          m_valid;
  logic [31:0] m_op_a, m_op_b, m_pc;
  int          m_op;
  logic [4:0]  m_rd, m_rs1, m_rs2;
  bit          m_imm;
  int          m_stall;

  alu_operand_stage dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
    .id_alu_op(id_alu_op), .id_use_imm(id_use_imm), .id_flush(id_flush),
    .mem_fwd_en(mem_fwd_en), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
    .wb_fwd_en(wb_fwd_en), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b),
    .ex_shamt(ex_shamt), .ex_shift_sel(ex_shift_sel), .ex_shift_arith(ex_shift_arith),
    .ex_alu_op(ex_alu_op), .ex_rd_addr(ex_rd_addr), .ex_pc(ex_pc),
    .ex_stall_cnt(ex_stall_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_fwd(input logic [4:0] idx, input logic [31:0] rf);
    if (idx == 0) return rf;
    if (mem_fwd_en && mem_fwd_rd == idx) return mem_fwd_data;
    if (wb_fwd_en && wb_fwd_rd == idx) return wb_fwd_data;
    return rf;
  endfunction

  task automatic model_clear();
    m_valid = 0; m_op_a = 0; m_op_b = 0; m_pc = 0; m_op = 0;
    m_rd = 0; m_rs1 = 0; m_rs2 = 0; m_imm = 0; m_stall = 0;
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
    id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0; id_alu_op = 0;
    id_use_imm = 0; id_flush = 0; ex_ready = 1;
    mem_fwd_en = 0; mem_fwd_rd = 0; mem_fwd_data = 0;
    wb_fwd_en = 0; wb_fwd_rd = 0; wb_fwd_data = 0;
  endtask

  // Apply the rules for one clock edge using the inputs currently driven.
  task automatic model_edge();
    bit rdy;
    rdy = !m_valid || ex_ready;
    if (id_flush) begin
      m_valid = 0;
      return;
    end
    if (m_valid && !ex_ready) begin
      if (m_stall < 65535) m_stall++;
      m_op_a = ref_fwd(m_rs1, m_op_a);
      if (!m_imm) m_op_b = ref_fwd(m_rs2, m_op_b);
    end
    if (id_valid && rdy) begin
      m_valid = 1;
      m_op_a  = ref_fwd(id_rs1_addr, id_rs1_data);
      m_op_b  = id_use_imm ? id_imm : ref_fwd(id_rs2_addr, id_rs2_data);
      m_op    = (id_alu_op <= 9) ? int'(id_alu_op) : 0;
      m_rd    = id_rd_addr; m_pc = id_pc;
      m_rs1   = id_rs1_addr; m_rs2 = id_rs2_addr; m_imm = id_use_imm;
    end else if (m_valid && ex_ready) begin
      m_valid = 0;
    end
  endtask

  task automatic compare_all();
    check("ex_valid", 32'(ex_valid), 32'(m_valid));
    check("stall_cnt", 32'(ex_stall_cnt), 32'(m_stall));
    if (m_valid) begin
      check("op_a", ex_op_a, m_op_a);
      check("op_b", ex_op_b, m_op_b);
      check("shamt", 32'(ex_shamt), 32'(m_op_b % 32));
      check("alu_op", 32'(ex_alu_op), 32'(m_op));
      check("shift_sel", 32'(ex_shift_sel), 32'(m_op == 6 || m_op == 7));
      check("shift_arith", 32'(ex_shift_arith), 32'(m_op == 7));
      check("rd", 32'(ex_rd_addr), 32'(m_rd));
      check("pc", ex_pc, m_pc);
    end
  endtask

  // Called at the falling edge after inputs are driven; returns at the next falling edge.
  task automatic step();
    #1;
    check("id_ready", 32'(id_ready), 32'(!m_valid || ex_ready));
    model_edge();
    @(posedge i_clk);
    #1;
    compare_all();
    @(negedge i_clk);
  endtask

  task automatic do_reset();
    i_rst_n = 0;
    idle_inputs();
    model_clear();
    repeat (2) @(negedge i_clk);
    check("rst_valid", 32'(ex_valid), 0);
    check("rst_ready", 32'(id_ready), 1);
    check("rst_op_a", ex_op_a, 0);
    check("rst_op_b", ex_op_b, 0);
    check("rst_misc", {ex_shamt, ex_shift_sel, ex_shift_arith, ex_alu_op, ex_rd_addr}, 0);
    check("rst_pc", ex_pc, 0);
    check("rst_cnt", 32'(ex_stall_cnt), 0);
    i_rst_n = 1;
    @(negedge i_clk);
  endtask

  initial begin
    i_rst_n = 1;
    idle_inputs();
    model_clear();
    @(negedge i_clk);
    do_reset();

    // SLL by immediate
    id_valid = 1; id_alu_op = 2; id_rs1_addr = 1; id_rs1_data = 32'h1;
    id_use_imm = 1; id_imm = 5; id_pc = 32'h100; id_rd_addr = 7;
    step();
    check("sll_valid", 32'(ex_valid), 1);
    check("sll_op_a", ex_op_a, 1);
    check("sll_shamt", 32'(ex_shamt), 5);
    check("sll_sel", {ex_shift_sel, ex_shift_arith}, 0);

    // SRA back-to-back, MEM beats WB on rs2
    id_alu_op = 7; id_use_imm = 0; id_rs2_addr = 3; id_rs2_data = 32'h99; id_pc = 32'h104;
    mem_fwd_en = 1; mem_fwd_rd = 3; mem_fwd_data = 32'h1F;
    wb_fwd_en = 1; wb_fwd_rd = 3; wb_fwd_data = 32'h4;
    step();
    check("sra_valid", 32'(ex_valid), 1);
    check("sra_shamt", 32'(ex_shamt), 31);
    check("sra_sel", {ex_shift_sel, ex_shift_arith}, 2'b11);
    check("sra_pc", ex_pc, 32'h104);

    // x0 never forwarded
    id_alu_op = 0; id_rs1_addr = 0; id_rs1_data = 0; id_pc = 32'h108;
    mem_fwd_rd = 0; mem_fwd_data = 32'hDEADBEEF; wb_fwd_en = 0;
    step();
    check("x0_op_a", ex_op_a, 0);

    // Four stalled cycles with a late WB producer in the second
    do_reset();
    id_valid = 1; id_alu_op = 0; id_rs1_addr = 5; id_rs1_data = 32'h11; id_pc = 32'h200;
    step();
    id_valid = 0; ex_ready = 0;
    for (int c = 1; c <= 4; c++) begin
      wb_fwd_en = (c == 2); wb_fwd_rd = 5; wb_fwd_data = 32'h55;
      #1 check("stall_id_ready", 32'(id_ready), 0);
      step();
      check("stall_op_a", ex_op_a, (c >= 2) ? 32'h55 : 32'h11);
    end
    wb_fwd_en = 0;
    check("stall_cnt4", 32'(ex_stall_cnt), 4);

    // Flush while full and stalled, with an incoming instruction
    id_flush = 1; id_valid = 1; id_pc = 32'h300;
    step();
    check("flush_valid", 32'(ex_valid), 0);
    check("flush_cnt", 32'(ex_stall_cnt), 4);
    id_flush = 0; id_valid = 0; ex_ready = 1;
    step();
    check("flush_stays_empty", 32'(ex_valid), 0);

    // Asynchronous reset mid-bundle
    id_valid = 1; id_pc = 32'h400;
    step();
    id_valid = 0; ex_ready = 0;
    step();
    #2 i_rst_n = 0;
    #1;
    check("async_rst_valid", 32'(ex_valid), 0);
    check("async_rst_cnt", 32'(ex_stall_cnt), 0);
    idle_inputs();
    model_clear();
    @(negedge i_clk);
    i_rst_n = 1;
    @(negedge i_clk);

    // Random traffic with overlapping register indices
    for (int i = 0; i < 3000; i++) begin
      id_valid     = ($urandom_range(0, 9) < 7);
      id_pc        = $urandom;
      id_rs1_data  = $urandom;
      id_rs2_data  = $urandom;
      id_imm       = $urandom;
      id_rs1_addr  = 5'($urandom_range(0, 3));
      id_rs2_addr  = 5'($urandom_range(0, 3));
      id_rd_addr   = 5'($urandom_range(0, 31));
      id_alu_op    = 4'($urandom_range(0, 15));
      id_use_imm   = 1'($urandom_range(0, 1));
      id_flush     = ($urandom_range(0, 15) == 0);
      ex_ready     = ($urandom_range(0, 3) != 0);
      mem_fwd_en   = 1'($urandom_range(0, 1));
      mem_fwd_rd   = 5'($urandom_range(0, 3));
      mem_fwd_data = $urandom;
      wb_fwd_en    = 1'($urandom_range(0, 1));
      wb_fwd_rd    = 5'($urandom_range(0, 3));
      wb_fwd_data  = $urandom;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_operand_stage.md
# alu_operand_stage

ID/EX pipeline register for the RV32I core. Captures decoded operands and forwards results from the MEM and WB stages. Derives the 5-bit shift amount, the left/right select and the arithmetic flag consumed by the ALU shifter. Presents one registered operand bundle per instruction to the ALU through a valid/ready handshake, and supports stall, flush and a stall-cycle counter.

## Interface
- No parameters; datapath fixed at 32 bits, register index 5 bits.
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset; asynchronous, active-low.
- id_valid  in  1  decode bundle valid.
- id_ready  out  1  stage can accept; = !ex_valid || ex_ready.
- id_pc  in  32  instruction PC.
- id_rs1_data, id_rs2_data  in  32  register-file read data.
- id_imm  in  32  sign-extended immediate.
- id_rs1_addr, id_rs2_addr, id_rd_addr  in  5  register indices.
- id_alu_op  in  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND; 10–15 reserved, treated as ADD.
- id_use_imm  in  1  operand B / shift amount from id_imm.
- id_flush  in  1  kill held and incoming instruction.
- mem_fwd_en, wb_fwd_en  in  1  MEM / WB stage writes a register.
- mem_fwd_rd, wb_fwd_rd  in  5  destination index.
- mem_fwd_data, wb_fwd_data  in  32  result data.
- ex_valid  out  1  bundle valid to ALU.
- ex_ready  in  1  ALU accepts bundle.
- ex_op_a, ex_op_b  out  32  ALU operands after forwarding.
- ex_shamt  out  5  shift amount.
- ex_shift_sel  out  1  0 = left, 1 = right.
- ex_shift_arith  out  1  1 for SRA.
- ex_alu_op  out  4  registered op, reserved codes mapped to 0.
- ex_rd_addr  out  5.
- ex_pc  out  32.
- ex_stall_cnt  out  16  saturating count of stalled cycles.

## Operation
- Single register slot with states EMPTY (ex_valid=0) and FULL (ex_valid=1).
- Capture: id_valid && id_ready && !id_flush; slot loads the bundle and becomes FULL.
- Drain: ex_valid && ex_ready with no capture; slot becomes EMPTY. Drain and capture in the same cycle replaces the bundle, back-to-back, with no bubble.
- Forwarding at capture, per source:
  - If index ≠ 0, mem_fwd_en is set and mem_fwd_rd matches, take mem_fwd_data.
  - Else if index ≠ 0, wb_fwd_en is set and wb_fwd_rd matches, take wb_fwd_data.
  - Else take register-file data. MEM has priority over WB.
- Forwarding while FULL and stalled (!ex_ready):
  - The held rs1/rs2 values are re-resolved each cycle with the same priority, using stored rs1/rs2 indices.
  - Held op_a/op_b and shamt update in place so late-arriving producers are observed.
  - Index 0 is never overwritten.
- op_a = forwarded rs1.
- op_b = id_use_imm ? id_imm : forwarded rs2.
- shamt = op_b[4:0]; upper bits of op_b are passed through unmodified to the ALU.
- shift_sel = 1 for ops 6 and 7, else 0.
- shift_arith = 1 only for op 7.
- For non-shift ops, shamt and shift_sel are still driven and the ALU ignores them.
- Flush: id_flush forces the slot EMPTY next edge, dropping both the held and any incoming bundle. Flush overrides capture and drain.
- Stall counter:
  - Increments when ex_valid && !ex_ready && !id_flush.
  - Saturates at 0xFFFF.
  - Cleared only by reset.

## Timing
- Latency: 1 cycle from capture edge to ex_valid=1 with the bundle.
- id_ready is combinational from ex_valid and ex_ready, with no combinational path from id_valid.
- Outputs are registered except id_ready and the in-place forwarding update, which is registered (visible the cycle after the producer).
- Reset asserted: ex_valid=0, all ex_* data outputs=0, ex_stall_cnt=0, id_ready=1.
- Reset mid-stall discards the bundle immediately, asynchronously.
- Bundle stability: while ex_valid && !ex_ready, all ex_* fields are stable except forwarded operand refresh.
- id_flush and ex_ready high together: flush wins, ex_valid=0 next cycle.

## Test plan
- Reset, then id_valid=1, op=2 (SLL), rs1_data=0x0000_0001, use_imm=1, imm=5 → next cycle ex_valid=1, op_a=1, shamt=5, shift_sel=0, shift_arith=0.
- op=7 (SRA), rs2_addr=3, mem_fwd rd=3 data=0x0000_001F, wb_fwd rd=3 data=0x4 → shamt=31, shift_sel=1, shift_arith=1 (MEM priority).
- rs1_addr=0, mem_fwd rd=0 data=0xDEAD_BEEF, rs1_data=0 → op_a=0.
- ex_ready=0 for 4 cycles with FULL; in cycle 2, wb_fwd rd=rs1 data=0x55 → op_a=0x55 from cycle 3; id_ready=0 throughout; ex_stall_cnt=4.
- Two back-to-back instructions with ex_ready=1 → two consecutive ex_valid cycles, no bubble, id_ready=1 continuously.
- FULL and stalled, assert id_flush with id_valid=1 → ex_valid=0 next cycle, incoming dropped; reset asserted mid-bundle → ex_valid=0 without a clock edge.
